// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline hazard logic: forward-select
// encodings, hazard FSM states and the default register-address width.
package pipe_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    WAIT  = 2'd2
  } hz_state_t;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forward select: the newest producer (EX/MEM) wins over MEM/WB;
// register 0 never forwards.
module fwd_select
  import pipe_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic [ADDR_W-1:0] srcTag,
  input  logic [ADDR_W-1:0] exmemRd,
  input  logic              exmemRegwrite,
  input  logic [ADDR_W-1:0] memwbRd,
  input  logic              memwbRegwrite,
  output logic [1:0]        sel
);

  logic exmemHit;
  logic memwbHit;

  always_comb begin
    exmemHit = exmemRegwrite && (exmemRd != '0) && (exmemRd == srcTag);
    memwbHit = memwbRegwrite && (memwbRd != '0) && (memwbRd == srcTag);
    sel      = FWD_RF;
    if (FWD_EN) begin
      if (exmemHit)      sel = FWD_EXMEM;
      else if (memwbHit) sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard controller beside the ID/EX register: operand forwarding, RAW stall
// countdown and data-memory wait freeze for the 5-stage MIPS pipeline.
module hazard_forward_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
  parameter bit          FWD_EN    = 1'b1,
  parameter bit          RF_BYPASS = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ifid_rs,
  input  logic [ADDR_W-1:0] ifid_rt,
  input  logic              ifid_uses_rt,
  input  logic [ADDR_W-1:0] idex_rs,
  input  logic [ADDR_W-1:0] idex_rt,
  input  logic [ADDR_W-1:0] idex_rd,
  input  logic              idex_regwrite,
  input  logic              idex_memread,
  input  logic [ADDR_W-1:0] exmem_rd,
  input  logic [ADDR_W-1:0] memwb_rd,
  input  logic              exmem_regwrite,
  input  logic              memwb_regwrite,
  input  logic              dmem_busy,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              idex_bubble,
  output logic              pipe_freeze,
  output logic [CNT_W-1:0]  stall_count
);

  function automatic logic tagMatch(input logic rw, input logic [ADDR_W-1:0] rd,
                                    input logic [ADDR_W-1:0] src);
    return rw && (rd != '0) && (rd == src);
  endfunction

  logic [1:0] selA;
  logic [1:0] selB;

  fwd_select #(.ADDR_W(ADDR_W), .FWD_EN(FWD_EN)) uFwdA (
    .srcTag        (idex_rs),
    .exmemRd       (exmem_rd),
    .exmemRegwrite (exmem_regwrite),
    .memwbRd       (memwb_rd),
    .memwbRegwrite (memwb_regwrite),
    .sel           (selA)
  );

  fwd_select #(.ADDR_W(ADDR_W), .FWD_EN(FWD_EN)) uFwdB (
    .srcTag        (idex_rt),
    .exmemRd       (exmem_rd),
    .exmemRegwrite (exmem_regwrite),
    .memwbRd       (memwb_rd),
    .memwbRegwrite (memwb_regwrite),
    .sel           (selB)
  );

  logic       exHit;
  logic       memHit;
  logic       wbHit;
  logic [1:0] needN;

  // Bubble requirement for the instruction currently in ID.
  always_comb begin
    exHit  = tagMatch(idex_regwrite, idex_rd, ifid_rs) ||
             (ifid_uses_rt && tagMatch(idex_regwrite, idex_rd, ifid_rt));
    memHit = tagMatch(exmem_regwrite, exmem_rd, ifid_rs) ||
             (ifid_uses_rt && tagMatch(exmem_regwrite, exmem_rd, ifid_rt));
    wbHit  = tagMatch(memwb_regwrite, memwb_rd, ifid_rs) ||
             (ifid_uses_rt && tagMatch(memwb_regwrite, memwb_rd, ifid_rt));
    needN  = 2'd0;
    if (FWD_EN) begin
      if (idex_memread && exHit) needN = 2'd1;
    end else begin
      if (exHit)       needN = RF_BYPASS ? 2'd2 : 2'd3;
      else if (memHit) needN = RF_BYPASS ? 2'd1 : 2'd2;
      else if (wbHit)  needN = RF_BYPASS ? 2'd0 : 2'd1;
    end
  end

  hz_state_t  state, nextState, savedState, nextSaved, effState;
  logic [1:0] cnt, nextCnt;
  logic       doStall;
  logic       doFreeze;

  // A WAIT cycle with the memory ready behaves exactly as the saved state.
  always_comb begin
    effState  = (state == WAIT && !dmem_busy) ? savedState : state;
    nextState = state;
    nextSaved = savedState;
    nextCnt   = cnt;
    doStall   = 1'b0;
    doFreeze  = 1'b0;
    case (effState)
      RUN: begin
        nextState = RUN;
        if (dmem_busy) begin
          doFreeze  = 1'b1;
          nextState = WAIT;
          nextSaved = RUN;
        end else if (needN != 2'd0) begin
          doStall = 1'b1;
          if (needN > 2'd1) begin
            nextCnt   = needN - 2'd1;
            nextState = STALL;
          end
        end
      end
      STALL: begin
        nextState = STALL;
        if (dmem_busy) begin
          doFreeze  = 1'b1;
          nextState = WAIT;
          nextSaved = STALL;
        end else begin
          doStall = 1'b1;
          nextCnt = cnt - 2'd1;
          if (cnt <= 2'd1) nextState = RUN;
        end
      end
      WAIT: begin
        doFreeze  = 1'b1;
        nextState = WAIT;
      end
      default: nextState = RUN;
    endcase
  end

  // Outputs are forced to their idle values while reset is asserted.
  always_comb begin
    pipe_freeze = rst_n && doFreeze;
    idex_bubble = rst_n && doStall && !doFreeze;
    pc_we       = !(pipe_freeze || idex_bubble);
    ifid_we     = !(pipe_freeze || idex_bubble);
    fwd_a       = rst_n ? selA : FWD_RF;
    fwd_b       = rst_n ? selB : FWD_RF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      savedState  <= RUN;
      cnt         <= '0;
      stall_count <= '0;
    end else begin
      state      <= nextState;
      savedState <= nextSaved;
      cnt        <= nextCnt;
      if (idex_bubble && (stall_count != '1)) stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed scoreboard bench for hazard_forward_ctrl across four parameter sets
// sharing one stimulus bus.
module tb_hazard_forward_ctrl;

  typedef struct packed {
    logic       rstN;
    logic [4:0] ifidRs;
    logic [4:0] ifidRt;
    logic       usesRt;
    logic [4:0] idexRs;
    logic [4:0] idexRt;
    logic [4:0] idexRd;
    logic       idexRw;
    logic       idexMr;
    logic [4:0] exmemRd;
    logic       exmemRw;
    logic [4:0] memwbRd;
    logic       memwbRw;
    logic       busy;
  } stim_t;

  typedef struct packed {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        pw;
    logic        iw;
    logic        bb;
    logic        fz;
    logic [15:0] sc;
  } resp_t;

  typedef struct packed {
    logic [1:0]  inst;
    logic [15:0] id;
    resp_t       exp;
  } chk_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;
  logic       ifid_uses_rt, idex_regwrite, idex_memread;
  logic       exmem_regwrite, memwb_regwrite, dmem_busy;

  always #5 clk = ~clk;

  // 0: forwarding; 1: stall-only, no bypass; 2: stall-only, bypass; 3: as 1 with 2-bit counter
  for (genvar g = 0; g < 4; g++) begin : gDut
    localparam bit          FE = (g == 0);
    localparam bit          RB = (g == 0 || g == 2);
    localparam int unsigned CW = (g == 3) ? 2 : 16;
    logic [1:0]    fa, fb;
    logic          pw, iw, bb, fz;
    logic [CW-1:0] scl;
    resp_t         r;
    hazard_forward_ctrl #(.ADDR_W(5), .FWD_EN(FE), .RF_BYPASS(RB), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
      .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
      .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
      .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
      .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
      .dmem_busy(dmem_busy),
      .fwd_a(fa), .fwd_b(fb), .pc_we(pw), .ifid_we(iw),
      .idex_bubble(bb), .pipe_freeze(fz), .stall_count(scl)
    );
    assign r = {fa, fb, pw, iw, bb, fz, 16'(scl)};
  end

  chk_t        q[$];
  int          applied = 0;
  int          miscompares = 0;
  logic [15:0] vecId = 16'd0;

  always @(negedge clk) begin
    chk_t  c;
    resp_t act;
    while (q.size() > 0) begin
      c = q.pop_front();
      case (c.inst)
        2'd0:    act = gDut[0].r;
        2'd1:    act = gDut[1].r;
        2'd2:    act = gDut[2].r;
        default: act = gDut[3].r;
      endcase
      applied++;
      if (act !== c.exp) begin
        miscompares++;
        $display("FAIL vec%0d inst%0d: got fa=%b fb=%b pc_we=%b ifid_we=%b bub=%b frz=%b cnt=%0d, want fa=%b fb=%b pc_we=%b ifid_we=%b bub=%b frz=%b cnt=%0d",
                 c.id, c.inst, act.fa, act.fb, act.pw, act.iw, act.bb, act.fz, act.sc,
                 c.exp.fa, c.exp.fb, c.exp.pw, c.exp.iw, c.exp.bb, c.exp.fz, c.exp.sc);
      end
    end
  end

  function automatic resp_t idleR(input logic [15:0] sc);
    return {2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, sc};
  endfunction
  function automatic resp_t stallR(input logic [15:0] sc);
    return {2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, sc};
  endfunction
  function automatic resp_t frzR(input logic [15:0] sc);
    return {2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, sc};
  endfunction

  task automatic apply(input stim_t s, input logic [1:0] inst, input resp_t e);
    @(posedge clk);
    #1;
    rst_n          = s.rstN;
    ifid_rs        = s.ifidRs;
    ifid_rt        = s.ifidRt;
    ifid_uses_rt   = s.usesRt;
    idex_rs        = s.idexRs;
    idex_rt        = s.idexRt;
    idex_rd        = s.idexRd;
    idex_regwrite  = s.idexRw;
    idex_memread   = s.idexMr;
    exmem_rd       = s.exmemRd;
    exmem_regwrite = s.exmemRw;
    memwb_rd       = s.memwbRd;
    memwb_regwrite = s.memwbRw;
    dmem_busy      = s.busy;
    q.push_back('{inst, vecId, e});
    vecId++;
  endtask

  stim_t IDLE;
  stim_t RST;

  task automatic resetFor(input logic [1:0] inst);
    apply(RST, inst, idleR(16'd0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    resp_t e;
    IDLE = '0;
    IDLE.rstN = 1'b1;
    RST = '0;
    rst_n = 1'b0;
    {ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd} = '0;
    {ifid_uses_rt, idex_regwrite, idex_memread, exmem_regwrite, memwb_regwrite, dmem_busy} = '0;

    // Reset state, then forwarding priority on the forwarding instance.
    resetFor(2'd0);
    apply(IDLE, 2'd0, idleR(16'd0));
    s = IDLE; s.exmemRd = 5'd5; s.exmemRw = 1'b1; s.memwbRd = 5'd5; s.memwbRw = 1'b1;
    s.idexRs = 5'd5;
    e = idleR(16'd0); e.fa = 2'b10; apply(s, 2'd0, e);
    s.idexRs = 5'd0; s.idexRt = 5'd5;
    e = idleR(16'd0); e.fb = 2'b10; apply(s, 2'd0, e);
    s.exmemRd = 5'd0; s.idexRs = 5'd5;
    e = idleR(16'd0); e.fa = 2'b01; e.fb = 2'b01; apply(s, 2'd0, e);
    s = IDLE; s.exmemRd = 5'd7; s.exmemRw = 1'b0; s.memwbRd = 5'd7; s.memwbRw = 1'b1;
    s.idexRs = 5'd7; s.idexRt = 5'd7;
    e = idleR(16'd0); e.fa = 2'b01; e.fb = 2'b01; apply(s, 2'd0, e);
    s = IDLE; s.exmemRd = 5'd0; s.exmemRw = 1'b1; s.memwbRd = 5'd0; s.memwbRw = 1'b1;
    apply(s, 2'd0, idleR(16'd0));

    // Load-use with forwarding: rt unused gives no stall, rs gives one bubble.
    resetFor(2'd0);
    s = IDLE; s.idexRw = 1'b1; s.idexMr = 1'b1; s.idexRd = 5'd8; s.ifidRt = 5'd8;
    apply(s, 2'd0, idleR(16'd0));
    s.ifidRt = 5'd0; s.ifidRs = 5'd8;
    apply(s, 2'd0, stallR(16'd0));
    s = IDLE; s.exmemRd = 5'd8; s.exmemRw = 1'b1; s.ifidRs = 5'd8;
    apply(s, 2'd0, idleR(16'd1));
    apply(IDLE, 2'd0, idleR(16'd1));

    // Load-use with memory busy in the same cycle: freeze first, bubble after.
    resetFor(2'd0);
    s = IDLE; s.idexRw = 1'b1; s.idexMr = 1'b1; s.idexRd = 5'd8; s.ifidRs = 5'd8; s.busy = 1'b1;
    apply(s, 2'd0, frzR(16'd0));
    s.busy = 1'b0;
    apply(s, 2'd0, stallR(16'd0));
    apply(IDLE, 2'd0, idleR(16'd1));

    // No forwarding, no bypass: EX producer on rt costs three bubbles.
    resetFor(2'd1);
    s = IDLE; s.idexRw = 1'b1; s.idexRd = 5'd3; s.ifidRt = 5'd3; s.usesRt = 1'b1;
    apply(s, 2'd1, stallR(16'd0));
    apply(s, 2'd1, stallR(16'd1));
    apply(s, 2'd1, stallR(16'd2));
    apply(IDLE, 2'd1, idleR(16'd3));
    resetFor(2'd1);
    s.usesRt = 1'b0;
    apply(s, 2'd1, idleR(16'd0));
    apply(IDLE, 2'd1, idleR(16'd0));

    // Bypass register file: rd=0 never stalls, MEM costs one, WB costs none.
    resetFor(2'd2);
    s = IDLE; s.idexRw = 1'b1; s.idexRd = 5'd0; s.ifidRs = 5'd0; s.ifidRt = 5'd0; s.usesRt = 1'b1;
    apply(s, 2'd2, idleR(16'd0));
    s = IDLE; s.exmemRd = 5'd4; s.exmemRw = 1'b1; s.ifidRs = 5'd4; s.idexRs = 5'd4;
    apply(s, 2'd2, stallR(16'd0));
    apply(IDLE, 2'd2, idleR(16'd1));
    s = IDLE; s.memwbRd = 5'd4; s.memwbRw = 1'b1; s.ifidRs = 5'd4; s.idexRs = 5'd4;
    apply(s, 2'd2, idleR(16'd1));

    // Memory busy for four cycles inside the stall: count holds, bubbles total three.
    resetFor(2'd1);
    s = IDLE; s.idexRw = 1'b1; s.idexRd = 5'd3; s.ifidRt = 5'd3; s.usesRt = 1'b1;
    apply(s, 2'd1, stallR(16'd0));
    apply(s, 2'd1, stallR(16'd1));
    s.busy = 1'b1;
    for (int i = 0; i < 4; i++) apply(s, 2'd1, frzR(16'd2));
    apply(IDLE, 2'd1, stallR(16'd2));
    apply(IDLE, 2'd1, idleR(16'd3));

    // Reset asserted mid-stall with the hazard still present.
    resetFor(2'd1);
    s = IDLE; s.idexRw = 1'b1; s.idexRd = 5'd3; s.ifidRt = 5'd3; s.usesRt = 1'b1;
    apply(s, 2'd1, stallR(16'd0));
    apply(s, 2'd1, stallR(16'd1));
    s.rstN = 1'b0;
    apply(s, 2'd1, idleR(16'd0));
    apply(IDLE, 2'd1, idleR(16'd0));

    // Two-bit counter saturates at 3 after six bubbles.
    resetFor(2'd3);
    s = IDLE; s.idexRw = 1'b1; s.idexRd = 5'd3; s.ifidRs = 5'd3;
    apply(s, 2'd3, stallR(16'd0));
    apply(s, 2'd3, stallR(16'd1));
    apply(s, 2'd3, stallR(16'd2));
    apply(IDLE, 2'd3, idleR(16'd3));
    apply(s, 2'd3, stallR(16'd3));
    apply(s, 2'd3, stallR(16'd3));
    apply(s, 2'd3, stallR(16'd3));
    apply(IDLE, 2'd3, idleR(16'd3));

    @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d checks left unconsumed, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
